// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_t;

  localparam logic [1:0]  RESULT_SRC_LOAD = 2'b01;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
// The memory stage wins over writeback; x0 never forwards.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/RAW stalls, branch flushes and
// multi-cycle MUL/DIV stall. Forwarding is enabled by defining HAZARD_FORWARDING_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RDE,
  input  logic [4:0] RDM,
  input  logic [4:0] RDW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulDivStartE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDivBusy
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MULDIV_CYCLES - 2);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_hz;
  logic [1:0]       fwd_a, fwd_b;

`ifdef HAZARD_FORWARDING_EN
  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RDM),
    .rd_w        (RDW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RDM),
    .rd_w        (RDW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign data_hz = (ResultSrcE == RESULT_SRC_LOAD) && (RDE != 5'd0) &&
                   ((RDE == Rs1D) || (RDE == Rs2D));

  logic unused_fwd;
  assign unused_fwd = RegWriteE;
`else
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;

  // Without forwarding, any in-flight E/M producer stalls; W relies on write-first regfile.
  assign data_hz = ((Rs1D != 5'd0) && ((RegWriteE && (RDE == Rs1D)) ||
                                       (RegWriteM && (RDM == Rs1D)))) ||
                   ((Rs2D != 5'd0) && ((RegWriteE && (RDE == Rs2D)) ||
                                       (RegWriteM && (RDM == Rs2D))));

  logic unused_fwd;
  assign unused_fwd = ^{Rs1E, Rs2E, RDW, RegWriteW, ResultSrcE};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle is the first stall cycle, so BUSY lasts MULDIV_CYCLES-2 cycles;
  // with a load value of 0 the start cycle alone covers the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MulDivStartE && !PCSrcE && (CntLoad != '0)) begin
          state_d = BUSY;
          cnt_d   = CntLoad;
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    logic idle, flush, md_stall, lu_stall;
    idle     = (state_q == IDLE);
    flush    = idle && PCSrcE;
    md_stall = (idle && MulDivStartE && !PCSrcE) || !idle;
    lu_stall = idle && !PCSrcE && data_hz;

    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MulDivBusy = 1'b0;
    ForwardAE  = FWD_REG;
    ForwardBE  = FWD_REG;
    if (!rst) begin
      StallF     = lu_stall || md_stall;
      StallD     = lu_stall || md_stall;
      StallE     = md_stall;
      FlushD     = flush;
      FlushE     = flush || lu_stall;
      FlushM     = md_stall;
      MulDivBusy = md_stall;
      ForwardAE  = fwd_a;
      ForwardBE  = fwd_b;
    end
  end

endmodule
